// File: rtl/cnu_pkg.sv
// Shared helpers and types for the serial min-sum check-node tracker:
// magnitude width, all-ones magnitude, clog2, and the sign-magnitude message layout.
package cnu_pkg;

  function automatic int mag_w(input int w);
    return w - 1;
  endfunction

  function automatic int mag_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int cnu_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  localparam int MSG_W = 6;

  typedef struct packed {
    logic               sgn;
    logic [MSG_W-2:0]   mag;
  } cnu_msg_t;

endpackage

// File: rtl/cnu_min_insert.sv
// Combinational insertion of one magnitude into a running (min1, min2, idx) triple.
// Strict less-than on min1 keeps the earliest index on ties; equal values fall to min2.
module cnu_min_insert
  import cnu_pkg::*;
#(
  parameter int MW   = 5,
  parameter int IDXW = 3
) (
  input  logic [MW-1:0]   min1,
  input  logic [MW-1:0]   min2,
  input  logic [IDXW-1:0] idx,
  input  logic [MW-1:0]   m,
  input  logic [IDXW-1:0] p,
  output logic [MW-1:0]   next_min1,
  output logic [MW-1:0]   next_min2,
  output logic [IDXW-1:0] next_idx
);

  always_comb begin
    next_min1 = min1;
    next_min2 = min2;
    next_idx  = idx;
    if (m < min1) begin
      next_min2 = min1;
      next_min1 = m;
      next_idx  = p;
    end else if (m < min2) begin
      next_min2 = m;
    end
  end

endmodule

// File: rtl/cnu_min_tracker.sv
// Serial check-node magnitude tracker: min1/min2/idx/sign-XOR over WC messages per frame.
// Optional offset min-sum output stage enabled by defining CNU_OFFSET_MS_EN.
module cnu_min_tracker
  import cnu_pkg::*;
#(
  parameter int W    = 6,
  parameter int WC   = 6,
  parameter int IDXW = cnu_clog2(WC),
  parameter int BETA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x_valid,
  input  logic [W-1:0]      x,
  input  logic              frame_clr,
  output logic [W-2:0]      min1,
  output logic [W-2:0]      min2,
  output logic [IDXW-1:0]   idx,
  output logic              sgn,
  output logic              out_valid,
  output logic              busy
);

  localparam int              MW      = mag_w(W);
  localparam logic [MW-1:0]   MAX_MAG = MW'(mag_max(W));
  localparam logic [IDXW-1:0] LAST    = IDXW'(WC - 1);

  logic [IDXW-1:0] count_reg;
  logic [MW-1:0]   acc_min1_reg, acc_min2_reg;
  logic [IDXW-1:0] acc_idx_reg;
  logic            acc_sgn_reg;
  logic [MW-1:0]   min1_reg, min2_reg;
  logic [IDXW-1:0] idx_reg;
  logic            sgn_reg, out_valid_reg;

  logic [MW-1:0]   ins_min1, ins_min2;
  logic [IDXW-1:0] ins_idx;
  logic [MW-1:0]   res_min1, res_min2;
  logic            ins_sgn;

  cnu_min_insert #(.MW(MW), .IDXW(IDXW)) u_insert (
    .min1      (acc_min1_reg),
    .min2      (acc_min2_reg),
    .idx       (acc_idx_reg),
    .m         (x[W-2:0]),
    .p         (count_reg),
    .next_min1 (ins_min1),
    .next_min2 (ins_min2),
    .next_idx  (ins_idx)
  );

  assign ins_sgn = acc_sgn_reg ^ x[W-1];

`ifdef CNU_OFFSET_MS_EN
  localparam logic [MW-1:0] BETA_V = MW'(BETA);
  // Saturating subtract so small minima clamp at zero instead of wrapping.
  assign res_min1 = (ins_min1 > BETA_V) ? ins_min1 - BETA_V : '0;
  assign res_min2 = (ins_min2 > BETA_V) ? ins_min2 - BETA_V : '0;
`else
  assign res_min1 = ins_min1;
  assign res_min2 = ins_min2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg     <= '0;
      acc_min1_reg  <= MAX_MAG;
      acc_min2_reg  <= MAX_MAG;
      acc_idx_reg   <= '0;
      acc_sgn_reg   <= 1'b0;
      min1_reg      <= '0;
      min2_reg      <= '0;
      idx_reg       <= '0;
      sgn_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (frame_clr) begin
        count_reg    <= '0;
        acc_min1_reg <= MAX_MAG;
        acc_min2_reg <= MAX_MAG;
        acc_idx_reg  <= '0;
        acc_sgn_reg  <= 1'b0;
      end else if (x_valid) begin
        if (count_reg == LAST) begin
          // Publish the frame including this message and re-arm for back-to-back frames.
          min1_reg      <= res_min1;
          min2_reg      <= res_min2;
          idx_reg       <= ins_idx;
          sgn_reg       <= ins_sgn;
          out_valid_reg <= 1'b1;
          count_reg     <= '0;
          acc_min1_reg  <= MAX_MAG;
          acc_min2_reg  <= MAX_MAG;
          acc_idx_reg   <= '0;
          acc_sgn_reg   <= 1'b0;
        end else begin
          count_reg    <= count_reg + 1'b1;
          acc_min1_reg <= ins_min1;
          acc_min2_reg <= ins_min2;
          acc_idx_reg  <= ins_idx;
          acc_sgn_reg  <= ins_sgn;
        end
      end
    end
  end

  assign min1      = min1_reg;
  assign min2      = min2_reg;
  assign idx       = idx_reg;
  assign sgn       = sgn_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (count_reg != '0);

endmodule
